// File: rtl/alu_rr_sched_pkg.sv
// Shared encodings for the round-robin ALU scheduler: ALU op codes and FSM states.
package alu_rr_sched_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or with overflow, negative and zero flags.
module alu
    import alu_rr_sched_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic [1:0]   ctrl,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] r,
    output logic         ovf,
    output logic         neg,
    output logic         zero
);

    always_comb begin
        r   = '0;
        ovf = 1'b0;
        unique case (ctrl)
            ALU_ADD: begin
                r   = a + b;
                ovf = (a[n-1] == b[n-1]) && (r[n-1] != a[n-1]);
            end
            ALU_SUB: begin
                r   = a - b;
                ovf = (a[n-1] != b[n-1]) && (r[n-1] != a[n-1]);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            default: r = '0;
        endcase
        neg  = r[n-1];
        zero = (r == '0);
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |valid;
        gnt_id    = (&valid) ? ~last_grant : valid[1];
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one ALU between two requesters: round-robin accept, execute, hold result until consumed.
module alu_rr_sched
    import alu_rr_sched_pkg::*;
#(
    parameter int unsigned n  = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [1:0]    req0_ctrl,
    input  logic [n-1:0]  req0_a,
    input  logic [n-1:0]  req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [1:0]    req1_ctrl,
    input  logic [n-1:0]  req1_a,
    input  logic [n-1:0]  req1_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [n-1:0]  rsp_r,
    output logic          rsp_o,
    output logic          rsp_n,
    output logic          rsp_z,
    output logic          busy,
    output logic [CW-1:0] ovf_cnt
);

    state_e       state_q;
    logic         last_grant_q;
    logic         op_id_q;
    logic [1:0]   op_ctrl_q;
    logic [n-1:0] op_a_q;
    logic [n-1:0] op_b_q;

    logic         gnt_valid;
    logic         gnt_id;
    logic [n-1:0] alu_r;
    logic         alu_ovf;
    logic         alu_neg;
    logic         alu_zero;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    alu #(
        .n (n)
    ) u_alu (
        .ctrl (op_ctrl_q),
        .a    (op_a_q),
        .b    (op_b_q),
        .r    (alu_r),
        .ovf  (alu_ovf),
        .neg  (alu_neg),
        .zero (alu_zero)
    );

    always_comb begin
        req0_ready = (state_q == StIdle) && gnt_valid && !gnt_id;
        req1_ready = (state_q == StIdle) && gnt_valid && gnt_id;
        busy       = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_id_q      <= 1'b0;
            op_ctrl_q    <= ALU_ADD;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_r        <= '0;
            rsp_o        <= 1'b0;
            rsp_n        <= 1'b0;
            rsp_z        <= 1'b0;
            ovf_cnt      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        op_ctrl_q    <= gnt_id ? req1_ctrl : req0_ctrl;
                        op_a_q       <= gnt_id ? req1_a : req0_a;
                        op_b_q       <= gnt_id ? req1_b : req0_b;
                        op_id_q      <= gnt_id;
                        last_grant_q <= gnt_id;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= op_id_q;
                    rsp_r     <= alu_r;
                    rsp_o     <= alu_ovf;
                    rsp_n     <= alu_neg;
                    rsp_z     <= alu_zero;
                    // Saturate rather than wrap so a full counter stays meaningful.
                    if (alu_ovf && (ovf_cnt != '1)) begin
                        ovf_cnt <= ovf_cnt + CW'(1);
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed scenarios plus a randomized transaction model.
module tb_alu_rr_sched;

    localparam int unsigned N = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          v0 = 1'b0, v1 = 1'b0;
    logic [1:0]    c0 = '0, c1 = '0;
    logic [N-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          rsp_ready = 1'b1;
    logic          ready0, ready1, rsp_valid, rsp_id, rsp_o, rsp_n, rsp_z, busy;
    logic [N-1:0]  rsp_r;
    logic [15:0]   ovf_cnt;
    logic          s_ready0, s_ready1, s_rsp_valid, s_rsp_id, s_rsp_o, s_rsp_n, s_rsp_z, s_busy;
    logic [N-1:0]  s_rsp_r;
    logic [1:0]    s_ovf_cnt;

    int checks = 0;
    int failures = 0;

    alu_rr_sched #(.n(N), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(ready0), .req0_ctrl(c0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(ready1), .req1_ctrl(c1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
        .rsp_o(rsp_o), .rsp_n(rsp_n), .rsp_z(rsp_z), .busy(busy), .ovf_cnt(ovf_cnt)
    );

    // Narrow-counter copy on the same stimulus, used for the saturation checks.
    alu_rr_sched #(.n(N), .CW(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(s_ready0), .req0_ctrl(c0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(s_ready1), .req1_ctrl(c1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_r(s_rsp_r),
        .rsp_o(s_rsp_o), .rsp_n(s_rsp_n), .rsp_z(s_rsp_z), .busy(s_busy), .ovf_cnt(s_ovf_cnt)
    );

    function automatic void ref_alu(input logic [1:0] c, input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] r, output logic o);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o = 1'b0;
        case (c)
            2'b00: begin s = sa + sb; r = s[N-1:0]; o = (s > MAXS) || (s < MINS); end
            2'b01: begin s = sa - sb; r = s[N-1:0]; o = (s > MAXS) || (s < MINS); end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
    endfunction

    function automatic logic [N-1:0] rnd_operand();
        case ($urandom_range(3, 0))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return N'($urandom_range(3, 0));
            default: return N'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        v0 = 1'b1; c0 = 2'b00; a0 = 32'h7FFF_FFFF; b0 = 32'h1;
        rst = 1'b1;
        tick();
        tick();
        v0 = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_o, rsp_n, rsp_z, busy} !== '0) begin
            failures++;
            $display("FAIL reset_rsp: got v=%b id=%b r=%h onz=%b%b%b busy=%b want all zero",
                     rsp_valid, rsp_id, rsp_r, rsp_o, rsp_n, rsp_z, busy);
        end
        checks++;
        if (ovf_cnt !== 16'd0 || s_ovf_cnt !== 2'd0) begin
            failures++;
            $display("FAIL reset_ovf: got %0d/%0d want 0/0", ovf_cnt, s_ovf_cnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        c0 = 2'b00; a0 = 32'd5; b0 = 32'd7; v0 = 1'b1;
        #1;
        checks++;
        if ({ready0, ready1} !== 2'b10) begin
            failures++;
            $display("FAIL basic_ready: got %b%b want 10", ready0, ready1);
        end
        tick();
        v0 = 1'b0;
        checks++;
        if ({busy, rsp_valid, ready0} !== 3'b100) begin
            failures++;
            $display("FAIL basic_exec: got busy/valid/ready %b%b%b want 100", busy, rsp_valid, ready0);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_o, rsp_n, rsp_z, busy} !== {2'b10, 32'd12, 4'b0001}) begin
            failures++;
            $display("FAIL basic_rsp: got v=%b id=%b r=%h onz=%b%b%b busy=%b want v=1 id=0 r=c onz=000 busy=1",
                     rsp_valid, rsp_id, rsp_r, rsp_o, rsp_n, rsp_z, busy);
        end
        tick();
        checks++;
        if ({rsp_valid, busy, rsp_r} !== {2'b00, 32'd12}) begin
            failures++;
            $display("FAIL basic_done: got v=%b busy=%b r=%h want v=0 busy=0 r=c", rsp_valid, busy, rsp_r);
        end
    endtask

    task automatic test_tie();
        do_reset();
        v0 = 1'b1; c0 = 2'b01; a0 = 32'd3; b0 = 32'd3;
        v1 = 1'b1; c1 = 2'b11; a1 = 32'h0F; b1 = 32'hF0;
        #1;
        checks++;
        if ({ready0, ready1} !== 2'b10) begin
            failures++;
            $display("FAIL tie_first: got %b%b want 10", ready0, ready1);
        end
        tick();
        v0 = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_z} !== {2'b10, 32'd0, 1'b1}) begin
            failures++;
            $display("FAIL tie_rsp0: got v=%b id=%b r=%h z=%b want v=1 id=0 r=0 z=1",
                     rsp_valid, rsp_id, rsp_r, rsp_z);
        end
        tick();
        checks++;
        if ({ready0, ready1} !== 2'b01) begin
            failures++;
            $display("FAIL tie_second: got %b%b want 01", ready0, ready1);
        end
        tick();
        v1 = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_n, rsp_z} !== {2'b11, 32'hFF, 2'b00}) begin
            failures++;
            $display("FAIL tie_rsp1: got v=%b id=%b r=%h want v=1 id=1 r=ff", rsp_valid, rsp_id, rsp_r);
        end
        tick();
        v0 = 1'b1; c0 = 2'b10; a0 = 32'hF0F0; b0 = 32'hFF00;
        v1 = 1'b1; c1 = 2'b00; a1 = 32'd1; b1 = 32'd2;
        #1;
        checks++;
        if ({ready0, ready1} !== 2'b10) begin
            failures++;
            $display("FAIL tie_third: got %b%b want 10", ready0, ready1);
        end
        tick();
        v0 = 1'b0;
        tick();
        checks++;
        if ({rsp_id, rsp_r} !== {1'b0, 32'hF000}) begin
            failures++;
            $display("FAIL tie_rsp2: got id=%b r=%h want id=0 r=f000", rsp_id, rsp_r);
        end
        tick();
        tick();
        v1 = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_r} !== {2'b11, 32'd3}) begin
            failures++;
            $display("FAIL tie_rsp3: got v=%b id=%b r=%h want v=1 id=1 r=3", rsp_valid, rsp_id, rsp_r);
        end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        v1 = 1'b1; c1 = 2'b00; a1 = 32'h7FFF_FFFF; b1 = 32'd1;
        tick();
        v1 = 1'b0;
        tick();
        checks++;
        if ({rsp_r, rsp_o, rsp_n, rsp_z, ovf_cnt} !== {32'h8000_0000, 3'b110, 16'd1}) begin
            failures++;
            $display("FAIL ovf_add: got r=%h onz=%b%b%b cnt=%0d want r=80000000 onz=110 cnt=1",
                     rsp_r, rsp_o, rsp_n, rsp_z, ovf_cnt);
        end
        tick();
        v1 = 1'b1; c1 = 2'b01; a1 = 32'h8000_0000; b1 = 32'd1;
        tick();
        v1 = 1'b0;
        tick();
        checks++;
        if ({rsp_r, rsp_o, rsp_n, rsp_z, ovf_cnt} !== {32'h7FFF_FFFF, 3'b100, 16'd2}) begin
            failures++;
            $display("FAIL ovf_sub: got r=%h onz=%b%b%b cnt=%0d want r=7fffffff onz=100 cnt=2",
                     rsp_r, rsp_o, rsp_n, rsp_z, ovf_cnt);
        end
        tick();
    endtask

    task automatic test_stall();
        v0 = 1'b1; c0 = 2'b00; a0 = 32'h100; b0 = 32'h23;
        rsp_ready = 1'b0;
        tick();
        v0 = 1'b0;
        v1 = 1'b1; c1 = 2'b11; a1 = 32'hA; b1 = 32'h5;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_r, ready0, ready1} !== {2'b10, 32'h123, 2'b00}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b id=%b r=%h rdy=%b%b want v=1 id=0 r=123 rdy=00",
                         i, rsp_valid, rsp_id, rsp_r, ready0, ready1);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, ready1, rsp_r} !== {2'b01, 32'h123}) begin
            failures++;
            $display("FAIL stall_release: got v=%b rdy1=%b r=%h want v=0 rdy1=1 r=123",
                     rsp_valid, ready1, rsp_r);
        end
        tick();
        v1 = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_r} !== {2'b11, 32'hF}) begin
            failures++;
            $display("FAIL stall_next: got v=%b id=%b r=%h want v=1 id=1 r=f", rsp_valid, rsp_id, rsp_r);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        v0 = 1'b1; c0 = 2'b00; a0 = 32'h7FFF_FFFF; b0 = 32'h7FFF_FFFF;
        tick();
        v0 = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, rsp_valid, ovf_cnt} !== 18'd0) begin
            failures++;
            $display("FAIL midrst_state: got busy=%b v=%b cnt=%0d want 0 0 0", busy, rsp_valid, ovf_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({rsp_valid, busy} !== 2'b00) begin
                failures++;
                $display("FAIL midrst_quiet[%0d]: got v=%b busy=%b want 0 0", i, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            v0 = 1'b1; c0 = 2'b01; a0 = 32'h8000_0000; b0 = 32'd1;
            tick();
            v0 = 1'b0;
            tick();
            checks++;
            if (int'(s_ovf_cnt) !== ((k > 3) ? 3 : k) || int'(ovf_cnt) !== k) begin
                failures++;
                $display("FAIL sat[%0d]: got cw2=%0d cw16=%0d want %0d %0d",
                         k, s_ovf_cnt, ovf_cnt, (k > 3) ? 3 : k, k);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic         m_last, acc0, acc1, e0, e1, e_id, e_o;
        logic [N-1:0] e_r;
        int           m_phase, m_cnt;
        do_reset();
        m_last = 1'b1;
        m_phase = 0;
        m_cnt = 0;
        e_id = 1'b0; e_o = 1'b0; e_r = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!v0 && $urandom_range(1, 0) == 1) begin
                v0 = 1'b1; c0 = 2'($urandom); a0 = rnd_operand(); b0 = rnd_operand();
            end
            if (!v1 && $urandom_range(1, 0) == 1) begin
                v1 = 1'b1; c1 = 2'($urandom); a1 = rnd_operand(); b1 = rnd_operand();
            end
            rsp_ready = ($urandom_range(3, 0) != 0);
            #1;
            e0 = 1'b0;
            e1 = 1'b0;
            if (m_phase == 0) begin
                if (v0 && v1) begin
                    e0 = m_last;
                    e1 = !m_last;
                end else begin
                    e0 = v0;
                    e1 = v1;
                end
            end
            checks++;
            if ({ready0, ready1} !== {e0, e1}) begin
                failures++;
                $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", cyc, ready0, ready1, e0, e1);
            end
            checks++;
            if (rsp_valid !== (m_phase == 2)) begin
                failures++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, rsp_valid, m_phase == 2);
            end
            if (m_phase == 2) begin
                checks++;
                if ({rsp_id, rsp_r, rsp_o, rsp_n, rsp_z} !== {e_id, e_r, e_o, e_r[N-1], e_r == '0}) begin
                    failures++;
                    $display("FAIL rnd_rsp[%0d]: got id=%b r=%h onz=%b%b%b want id=%b r=%h onz=%b%b%b",
                             cyc, rsp_id, rsp_r, rsp_o, rsp_n, rsp_z, e_id, e_r, e_o, e_r[N-1], e_r == '0);
                end
                checks++;
                if (int'(ovf_cnt) !== m_cnt || int'(s_ovf_cnt) !== ((m_cnt > 3) ? 3 : m_cnt)) begin
                    failures++;
                    $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", cyc, ovf_cnt, s_ovf_cnt,
                             m_cnt, (m_cnt > 3) ? 3 : m_cnt);
                end
            end
            acc0 = 1'b0;
            acc1 = 1'b0;
            case (m_phase)
                0: if (e0 || e1) begin
                    acc0 = e0;
                    acc1 = e1;
                    e_id = e1;
                    m_last = e1;
                    if (e1) ref_alu(c1, a1, b1, e_r, e_o);
                    else ref_alu(c0, a0, b0, e_r, e_o);
                    m_phase = 1;
                end
                1: begin
                    m_phase = 2;
                    if (e_o) m_cnt++;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
            tick();
            if (acc0) v0 = 1'b0;
            if (acc1) v1 = 1'b0;
        end
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
